// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and instruction/ROM geometry.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    localparam int INSTR_BYTES = 3;
    localparam int INSTR_W     = 24;
    localparam int ROM_ADDR_W  = 6;
    localparam int ROM_DATA_W  = 8;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: reads three ROM bytes per instruction, assembles a 24-bit word,
// presents it over valid/ready, and follows branch redirects.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = ROM_ADDR_W,
    parameter int                 DATA_W    = ROM_DATA_W,
    parameter logic [ADDR_W-1:0]  PC_RESET  = '0,
    parameter logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(32)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            br_valid,
    input  logic [ADDR_W-1:0]               br_addr,
    output logic [ADDR_W-1:0]               rom_addr,
    output logic                            rom_cs,
    input  logic [DATA_W-1:0]               rom_data,
    output logic [INSTR_BYTES*DATA_W-1:0]   instr,
    output logic                            instr_valid,
    input  logic                            instr_ready,
    output logic [ADDR_W-1:0]               pc_out,
    output logic                            busy,
    output logic                            done
);

    localparam int WORD_W = INSTR_BYTES * DATA_W;

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0]     instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]     pc_out_q, pc_out_d;
    logic                  launch;
    logic [ADDR_W-1:0]     launch_pc;
    logic [1:0]            lane;

    // The end check uses the unwrapped sum so a word straddling the top never starts.
    function automatic logic fits_in_rom(logic [ADDR_W-1:0] p);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, p} + (ADDR_W+1)'(INSTR_BYTES - 1);
        return last_byte <= {1'b0, LAST_ADDR};
    endfunction

    assign lane = 2'(INSTR_BYTES - 1) - byte_idx_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rom_addr_d    = rom_addr_q;
        byte_idx_d    = byte_idx_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        launch        = 1'b0;
        launch_pc     = pc_q;

        if (br_valid) begin
            // A redirect overrides everything, including an acceptance in HOLD.
            pc_d          = br_addr;
            instr_valid_d = 1'b0;
            launch        = 1'b1;
            launch_pc     = br_addr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) launch = 1'b1;
                end
                ST_FETCH: begin
                    instr_d[lane*DATA_W +: DATA_W] = rom_data;
                    rom_addr_d = pc_q + ADDR_W'(byte_idx_q) + ADDR_W'(1);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(INSTR_BYTES - 1)) begin
                        instr_valid_d = 1'b1;
                        pc_out_d      = pc_q;
                        state_d       = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        pc_d          = pc_q + ADDR_W'(INSTR_BYTES);
                        launch        = 1'b1;
                        launch_pc     = pc_d;
                    end
                end
                default: ;
            endcase
        end

        if (launch) begin
            if (fits_in_rom(launch_pc)) begin
                rom_addr_d = launch_pc;
                byte_idx_d = 2'd0;
                state_d    = ST_FETCH;
            end else begin
                state_d    = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= PC_RESET;
            rom_addr_q    <= PC_RESET;
            byte_idx_q    <= 2'd0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_addr_q    <= rom_addr_d;
            byte_idx_q    <= byte_idx_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_cs      = (state_q == ST_FETCH);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_HOLD);
    assign done        = (state_q == ST_DONE);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Reader side of the 6-bit-address / 8-bit-data instruction ROM interface. Drives address and chip-select into the ROM.
- Assembles three consecutive bytes into one 24-bit instruction word.
- Hands each word to the decoder over a valid/ready handshake.
- Owns the program counter and supports branch redirects.
- Sits between the ROM and the control/decode unit of the CPU.

Parameters:
- ADDR_W, 6, ROM address width.
- DATA_W, 8, ROM data width.
- PC_RESET, 6'h00, PC value after reset.
- LAST_ADDR, 6'h20, highest valid ROM byte address.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins fetching from current PC (honoured in IDLE only).
- br_valid  input  1  redirect request.
- br_addr  input  6  redirect target byte address.
- rom_addr  output  6  registered byte address to ROM.
- rom_cs  output  1  ROM chip select.
- rom_data  input  8  ROM byte for the current rom_addr (combinational, settles within the cycle).
- instr  output  24  assembled instruction; byte at PC in bits [23:16], PC+1 in [15:8], PC+2 in [7:0].
- instr_valid  output  1  instr and pc_out are valid.
- instr_ready  input  1  decoder accepts instr.
- pc_out  output  6  byte address of the first byte of instr.
- busy  output  1  high in FETCH or HOLD.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-fetch):
  - state=IDLE, pc=PC_RESET, rom_addr=PC_RESET, byte_idx=0.
  - rom_cs=0, instr=0, instr_valid=0, pc_out=0, busy=0, done=0.
- Input priority at each edge: rst > br_valid > instr_ready/start.
- Launch check, applied whenever entering FETCH from pc value P:
  - Compute P+2 in 7 bits.
  - If P+2 > LAST_ADDR: go to DONE and never assert rom_cs.
  - Otherwise: rom_addr<=P, byte_idx<=0, state<=FETCH.
- IDLE:
  - start=1 performs the launch check with P=pc.
- FETCH:
  - rom_cs=1 throughout.
  - Each cycle, capture rom_data into the byte lane byte_idx; rom_addr<=pc+byte_idx+1 (mod 64); byte_idx<=byte_idx+1.
  - On the edge that captures byte 2: instr_valid<=1, pc_out<=pc, state<=HOLD.
  - Latency: start edge S, bytes captured at edges S+1..S+3, instr_valid high from S+3 (visible in cycle S+4).
- HOLD:
  - rom_cs=0; instr and pc_out held stable while instr_ready=0.
  - instr_ready=1 at an edge: instr_valid<=0, pc<=pc+3, then launch check with P=pc+3.
  - Back-to-back instructions therefore arrive every 4 cycles.
- Branch (br_valid=1 at an edge, in any state):
  - pc<=br_addr; any partial bytes are discarded.
  - instr_valid<=0; an instruction in HOLD is dropped unaccepted, even if instr_ready=1 in the same cycle.
  - Launch check with P=br_addr.
  - This is the only exit from DONE other than rst.
- DONE:
  - done=1, rom_cs=0, instr_valid=0.
  - start is ignored.
- Arithmetic:
  - PC and address arithmetic wraps modulo 64.
  - The end check uses the unwrapped 7-bit sum.
  - Branch targets need no alignment to multiples of 3.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch state encoding (IDLE, FETCH, HOLD, DONE);
  - INSTR_BYTES=3 and INSTR_W=24;
  - ROM_ADDR_W and ROM_DATA_W.
- No sub-module: a single FSM plus the byte-assembly register.
- The bench instantiates the existing ROM as the stimulus source.

Test Plan:
1. rst, start at pc=0, instr_ready tied 1 -> 11 instructions with pc_out 0x00,0x03,…,0x1E. pc_out=0x06 gives instr=0x004000; pc_out=0x0C gives 0x004141; pc_out=0x15 gives 0x0000E0; pc_out=0x1E gives 0x000055. Then done=1 with no rom_cs pulse at 0x21.
2. Back-pressure: hold instr_ready=0 for 5 cycles at pc_out=0x06 -> instr stays 0x004000 and instr_valid stays 1. Release -> next instruction has pc_out=0x09, instr_valid rises 4 cycles after acceptance.
3. br_valid with br_addr=0x0C on the second FETCH cycle of pc=0x03 -> partial word discarded. Next valid word is instr=0x004141, pc_out=0x0C, 4 cycles after the branch edge.
4. br_valid with br_addr=0x1F in IDLE -> done=1 next cycle, rom_cs never asserted. br_valid with br_addr=0x1E from DONE -> instr=0x000055 delivered.
5. br_valid and instr_ready both 1 in HOLD -> branch wins; the held word is dropped and pc follows br_addr.
6. rst asserted mid-FETCH (byte_idx=1) -> next cycle all outputs 0, rom_addr=PC_RESET, state IDLE. A fresh start refetches pc 0x00 correctly.
